// File: rtl/lcg_step_core.sv
// lcg_step_core: multi-cycle LCG state update x' = ((1 + 2^r)*x + b) mod 2^N,
// built from shift-and-add with no multiplier. Each new state is offered to the
// downstream stage through a valid/ready handshake.
module lcg_step_core #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          seed_load,
  input  logic [N-1:0]  seed,
  input  logic          step,
  input  logic [N-1:0]  r,
  input  logic [N-1:0]  b,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  x_out,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_ADD_X = 3'd2,
    S_ADD_B = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [N-1:0]  r_x_state;
  logic [N-1:0]  r_tmp;
  logic [N-1:0]  r_shamt;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_x_out;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_out_valid;

  logic [N-1:0]  w_x_state_nxt;
  logic [N-1:0]  w_tmp_nxt;
  logic [N-1:0]  w_shamt_nxt;
  logic [N-1:0]  w_b_nxt;
  logic [N-1:0]  w_x_out_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_busy_nxt;
  logic          w_out_valid_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; seed_load wins over step, and HOLD waits for the consumer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!seed_load && step) w_state_nxt = S_SHIFT;
      S_SHIFT: w_state_nxt = S_ADD_X;
      S_ADD_X: w_state_nxt = S_ADD_B;
      S_ADD_B: w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    w_x_state_nxt   = r_x_state;
    w_tmp_nxt       = r_tmp;
    w_shamt_nxt     = r_shamt;
    w_b_nxt         = r_b;
    w_x_out_nxt     = r_x_out;
    w_count_nxt     = r_count;
    w_busy_nxt      = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_ADD_X) ||
                      (w_state_nxt == S_ADD_B);
    w_out_valid_nxt = (w_state_nxt == S_HOLD);
    case (r_state)
      S_IDLE: begin
        if (seed_load) begin
          w_x_state_nxt = seed;
          w_x_out_nxt   = seed;
          w_count_nxt   = '0;
        end else if (step) begin
          w_shamt_nxt = r;
          w_b_nxt     = b;
          w_tmp_nxt   = r_x_state;
        end
      end
      S_SHIFT: begin
        // Shifts of N or more push every bit out of the word
        w_tmp_nxt = (r_shamt >= N'(N)) ? '0 : N'(r_tmp << r_shamt);
      end
      S_ADD_X: begin
        w_tmp_nxt = N'(r_tmp + r_x_state);
      end
      S_ADD_B: begin
        w_x_state_nxt = N'(r_tmp + r_b);
        w_x_out_nxt   = N'(r_tmp + r_b);
        w_count_nxt   = CW'(r_count + CW'(1));
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_state   <= '0;
      r_tmp       <= '0;
      r_shamt     <= '0;
      r_b         <= '0;
      r_x_out     <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_x_state   <= w_x_state_nxt;
      r_tmp       <= w_tmp_nxt;
      r_shamt     <= w_shamt_nxt;
      r_b         <= w_b_nxt;
      r_x_out     <= w_x_out_nxt;
      r_count     <= w_count_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign x_out     = r_x_out;
  assign count     = r_count;

endmodule

// File: tb/tb_lcg_step_core.sv
// Directed bench for lcg_step_core; a second instance with a 2-bit counter
// shares all inputs to exercise counter wrap.
module tb_lcg_step_core;

  logic       clk;
  logic       rst_n;
  logic       seed_load;
  logic [3:0] seed;
  logic       step;
  logic [3:0] r;
  logic [3:0] b;
  logic       out_ready;
  logic       busy, out_valid;
  logic [3:0] x_out;
  logic [7:0] count;
  logic       busy2, out_valid2;
  logic [3:0] x_out2;
  logic [1:0] count2;

  int checks;
  int failures;

  lcg_step_core #(.N(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .step(step),
    .r(r), .b(b), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .count(count)
  );

  lcg_step_core #(.N(4), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .step(step),
    .r(r), .b(b), .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready),
    .x_out(x_out2), .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [3:0] s);
    seed_load = 1'b1;
    seed      = s;
    tick();
    seed_load = 1'b0;
    chk("seed_x_out", x_out, s);
    chk("seed_count", count, 0);
    chk("seed_valid", out_valid, 0);
  endtask

  // One full iteration with the consumer ready; checks busy window and result
  task automatic do_iter(input logic [3:0] rv, input logic [3:0] bv,
                         input logic [3:0] ex, input logic [7:0] ec);
    step      = 1'b1;
    r         = rv;
    b         = bv;
    out_ready = 1'b1;
    tick();                       // E0
    step = 1'b0;
    r    = rv ^ 4'hF;             // must not disturb the running iteration
    b    = bv ^ 4'hA;
    chk("e0_busy", busy, 1);
    chk("e0_valid", out_valid, 0);
    tick();                       // E1
    chk("e1_busy", busy, 1);
    tick();                       // E2
    chk("e2_busy", busy, 1);
    chk("e2_valid", out_valid, 0);
    tick();                       // E3
    chk("e3_busy", busy, 0);
    chk("e3_valid", out_valid, 1);
    chk("e3_x_out", x_out, ex);
    chk("e3_count", count, ec);
    chk("e3_count_cw2", count2, 32'(ec[1:0]));
    tick();                       // E4 handshake
    chk("e4_valid", out_valid, 0);
    chk("e4_x_out", x_out, ex);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed      = 4'd0;
    step      = 1'b0;
    r         = 4'd0;
    b         = 4'd0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_x_out", x_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    tick();

    // Basic: 3*3+1 = 10
    do_seed(4'd3);
    do_iter(4'd1, 4'd1, 4'd10, 8'd1);
    // Chained: 10*3+1 = 31 -> 15, 15*3+1 = 46 -> 14
    do_iter(4'd1, 4'd1, 4'd15, 8'd2);
    do_iter(4'd1, 4'd1, 4'd14, 8'd3);

    // Oversized shift: 0 + 3 + 1 = 4
    do_seed(4'd3);
    do_iter(4'd5, 4'd1, 4'd4, 8'd1);

    // Backpressure: 4*3+1 = 13, held for 10 cycles while inputs churn
    step      = 1'b1;
    r         = 4'd1;
    b         = 4'd1;
    out_ready = 1'b0;
    tick();
    step = 1'b0;
    tick();
    tick();
    tick();
    chk("bp_valid_rise", out_valid, 1);
    chk("bp_x_out_rise", x_out, 13);
    for (int i = 0; i < 10; i++) begin
      step = ~step;
      r    = 4'(i);
      b    = 4'(i + 3);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_x_out", x_out, 13);
      chk("bp_count", count, 2);
      chk("bp_busy", busy, 0);
    end
    step      = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    // Immediately back in IDLE: (1+1)*13 + 0 = 26 -> 10
    do_iter(4'd0, 4'd0, 4'd10, 8'd3);

    // Priority: seed_load beats step
    seed_load = 1'b1;
    seed      = 4'd7;
    step      = 1'b1;
    r         = 4'd1;
    b         = 4'd1;
    tick();
    seed_load = 1'b0;
    step      = 1'b0;
    chk("prio_x_out", x_out, 7);
    chk("prio_count", count, 0);
    chk("prio_busy", busy, 0);
    tick();
    chk("prio_busy_next", busy, 0);
    chk("prio_valid_next", out_valid, 0);
    // From 7: 22->6, 19->3, 10, 31->15; 2-bit counter wraps to 0 on the 4th
    do_iter(4'd1, 4'd1, 4'd6, 8'd1);
    do_iter(4'd1, 4'd1, 4'd3, 8'd2);
    do_iter(4'd1, 4'd1, 4'd10, 8'd3);
    do_iter(4'd1, 4'd1, 4'd15, 8'd4);
    chk("wrap_count_cw2", count2, 0);

    // Reset while in ADD_X
    step = 1'b1;
    r    = 4'd1;
    b    = 4'd1;
    tick();                       // into SHIFT
    step = 1'b0;
    tick();                       // into ADD_X
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_x_out", x_out, 0);
    chk("amid_valid", out_valid, 0);
    chk("amid_busy", busy, 0);
    chk("amid_count", count, 0);
    chk("amid_count_cw2", count2, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_x_out", x_out, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcg_step_core.md
Name: lcg_step_core

Overview:
- Sequential LCG state-update stage for the modified dual-CLCG datapath.
- Computes x(i+1) = ((1 + 2^r)·x(i) + b) mod 2^N over several clock cycles, using shift-and-add with no multiplier.
- Feeds the downstream shift/hold register stage: x_out connects to that stage's parallel input.
- Holds LCG state, accepts seeds and step requests, and delivers each new state through a valid/ready handshake.

Parameters:
N, 4, state/word width in bits
CW, 8, width of the generated-sample counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
seed_load  input  1  load seed into LCG state (accepted only in IDLE)
seed  input  N  seed value
step  input  1  request one LCG iteration (accepted only in IDLE)
r  input  N  multiplier shift amount, sampled when step is accepted
b  input  N  additive increment, sampled when step is accepted
busy  output  1  high in SHIFT, ADD_X, ADD_B
out_valid  output  1  x_out holds a new, unconsumed state
out_ready  input  1  downstream accepts x_out
x_out  output  N  most recent LCG state
count  output  CW  number of states produced since last seed/reset, wraps mod 2^CW

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; internal x_state, tmp, r_q, b_q = 0.
  - Outputs: x_out=0, out_valid=0, busy=0, count=0.
  - Reset mid-operation aborts the iteration; no output is produced after release.
- FSM states: IDLE, SHIFT, ADD_X, ADD_B, HOLD.
- IDLE:
  - seed_load=1: x_state<=seed, x_out<=seed, count<=0. Stay in IDLE. out_valid stays 0.
  - seed_load has priority over step in the same cycle. step is then ignored, not queued.
  - step=1, seed_load=0: r_q<=r, b_q<=b, tmp<=x_state. Go to SHIFT.
- SHIFT:
  - tmp <= tmp << r_q, truncated to N bits.
  - r_q >= N yields tmp=0.
  - Go to ADD_X.
- ADD_X: tmp <= (tmp + x_state) mod 2^N. Go to ADD_B.
- ADD_B:
  - x_state and x_out <= (tmp + b_q) mod 2^N.
  - out_valid<=1; count<=count+1 (wraps to 0 after 2^CW-1).
  - Go to HOLD.
- HOLD:
  - out_valid=1 and x_out stable until out_ready=1 is sampled.
  - On that edge, out_valid<=0 and the FSM goes to IDLE.
  - step and seed_load are ignored in HOLD.
- Outside IDLE, step, seed_load, seed, r and b are don't-care.
  - Changes to r/b after acceptance do not affect the running iteration.
- Latency:
  - Step accepted on edge E0 → out_valid high after edge E3.
  - If out_ready is already high, the handshake completes on E4.
  - The earliest next step is accepted on E5, giving a minimum 5-cycle period per sample.
- busy is registered: high after E0 through E2, low after E3.
- All arithmetic is unsigned mod 2^N. Carries are discarded, with no overflow flag.
- x_out is registered and changes only on seed_load in IDLE or in ADD_B.

Test Plan:
- Basic iteration:
  - Stimulus: reset, N=4, seed_load seed=3, step with r=1, b=1, out_ready=1.
  - Response: out_valid high after E3 with x_out=10 and count=1; busy high exactly 3 cycles.
- Chained iterations:
  - Stimulus: repeat step (r=1, b=1) two more times.
  - Response: x_out=15 then 14 (46 mod 16); count=3; steps issued in HOLD are ignored.
- Oversized shift:
  - Stimulus: seed=3, r=5, b=1.
  - Response: x_out=4 (shift term 0).
- Backpressure:
  - Stimulus: hold out_ready low for 10 cycles after out_valid, toggling step, r and b meanwhile.
  - Response: x_out and out_valid stable; count unchanged; IDLE entered one edge after out_ready rises.
- Priority and count wrap:
  - Stimulus: assert seed_load=1, seed=7, together with step in IDLE.
  - Response: x_state=7, count=0, no iteration, busy stays 0.
  - Stimulus: with CW=2, do 4 iterations.
  - Response: count=0 after the 4th.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously while in ADD_X.
  - Response: immediately x_out=0, out_valid=0, busy=0, count=0; after release, no spurious out_valid.
